pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
- Generator side of the PC-enable path. Produces the PC enable (PCEn), the IF/ID register enable and the ID/EX bubble flush for the 5-stage pipeline.
- Sources of stall:
  - pipeline-fill window after reset;
  - load-use data hazards;
  - multi-cycle data-memory accesses (req/ready handshake).
- PCEn is always a defined 0/1 from the first clock edge after reset. It is never x, so downstream enable logic needs no x-override.

Parameters:
- FILL_CYCLES, 2, cycles after reset release during which PCEn=1 and the hazard checks are ignored (pipeline registers are not yet valid).
- MEM_TIMEOUT, 16, maximum cycles a memory stall may last before mem_err is raised.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  source register rs of the instruction in ID.
- id_rt  in  5  source register rt of the instruction in ID.
- id_uses_rt  in  1  1 = the ID instruction reads rt.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rt  in  5  destination register of the EX-stage load.
- mem_req  in  1  MEM stage starts or holds a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- PCEn  out  1  PC write enable.
- IFIDEn  out  1  IF/ID register enable.
- IDEXFlush  out  1  1 = load a bubble (NOP) into ID/EX.
- mem_stall  out  1  1 = all stages frozen for memory wait (EX/MEM and MEM/WB enables must be gated with it).
- mem_err  out  1  sticky; memory timeout occurred.
- stall_cnt  out  CNT_W  number of cycles with PCEn=0; saturates at all-ones.

Behaviour:
- Reset (asynchronous):
  - state=FILL, fill counter=0, wait counter=0, stall_cnt=0, mem_err=0.
  - Outputs during reset: PCEn=1, IFIDEn=1, IDEXFlush=0, mem_stall=0.
- FSM states: FILL, RUN, MEMWAIT.
- FILL:
  - PCEn=1, IFIDEn=1, IDEXFlush=0, mem_stall=0. All inputs are ignored.
  - The fill counter increments each cycle; move to RUN when it reaches FILL_CYCLES-1.
  - FILL_CYCLES=0 means RUN directly out of reset.
- RUN:
  - load_use = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
  - mem_req & ~mem_ready:
    - same cycle: PCEn=0, IFIDEn=0, mem_stall=1, IDEXFlush=0;
    - next state MEMWAIT, wait counter=1.
  - mem_req & mem_ready (single-cycle access): no stall.
  - else load_use: PCEn=0, IFIDEn=0, IDEXFlush=1 for exactly that cycle; stay in RUN.
  - else: PCEn=1, IFIDEn=1, IDEXFlush=0.
  - A memory stall takes priority over load-use. The load-use condition is re-evaluated after the memory stall ends.
- MEMWAIT:
  - PCEn=0, IFIDEn=0, mem_stall=1, IDEXFlush=0.
  - mem_ready=1 → RUN next cycle. Outputs in that ready cycle remain stalled, so the data is captured on that edge.
  - mem_ready=0: wait counter increments.
  - Wait counter reaches MEM_TIMEOUT: set mem_err=1 and force return to RUN, abandoning the access.
  - mem_req dropping without mem_ready is treated as ready.
- All outputs are combinational from state plus current inputs. There are no registered-output latencies except the state transitions above.
- stall_cnt increments on every clock edge where PCEn=0 and saturates.
- mem_err is cleared only by rst.
- rst mid-MEMWAIT or mid-stall: immediate return to FILL with all counters cleared. An outstanding memory access is abandoned.

Test Plan:
1. Reset release with FILL_CYCLES=2, ex_memread=1 and ex_rt=id_rs=5 held → PCEn=1 for 2 cycles, then PCEn=0 and IDEXFlush=1 in cycle 3.
2. RUN with ex_memread=1, ex_rt=8, id_rt=8:
   - id_uses_rt=1 → PCEn=0, IFIDEn=0, IDEXFlush=1 for one cycle; stall_cnt +1.
   - Same with id_uses_rt=0, or with ex_rt=0 → no stall.
3. mem_req=1, mem_ready=0 for 3 cycles, then ready=1 → mem_stall=1 and PCEn=0 for 4 cycles, PCEn=1 the following cycle; stall_cnt=4.
4. mem_req=1 and load_use true simultaneously → mem_stall=1 and IDEXFlush=0. After ready, one load-use bubble (IDEXFlush=1) if the hazard persists.
5. mem_req=1, mem_ready never asserted, MEM_TIMEOUT=16 → mem_err=1 after 16 stall cycles; FSM back in RUN with PCEn=1; mem_err stays 1 until rst.
6. Assert rst during cycle 2 of MEMWAIT → PCEn=1 and mem_stall=0 immediately (asynchronous); stall_cnt=0; FILL sequence restarts.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Stall generator for the 5-stage pipeline. Drives the PC write
//               enable, the IF/ID register enable and the ID/EX bubble flush.
//               Stall sources are the post-reset pipeline-fill window,
//               load-use data hazards and multi-cycle data-memory accesses.
//
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               id_rs      - rs of the instruction in ID
//               id_rt      - rt of the instruction in ID
//               id_uses_rt - ID instruction reads rt
//               ex_memread - EX-stage instruction is a load
//               ex_rt      - destination register of the EX-stage load
//               mem_req    - MEM stage starts or holds a data-memory access
//               mem_ready  - data memory completes the access this cycle
//               PCEn       - PC write enable
//               IFIDEn     - IF/ID register enable
//               IDEXFlush  - load a bubble into ID/EX
//               mem_stall  - whole pipeline frozen for a memory wait
//               mem_err    - sticky memory-timeout flag
//               stall_cnt  - saturating count of cycles with PCEn=0
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int FILL_CYCLES = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PCEn,
    output logic             IFIDEn,
    output logic             IDEXFlush,
    output logic             mem_stall,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int FILL_W = (FILL_CYCLES > 2) ? $clog2(FILL_CYCLES) : 1;
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'((FILL_CYCLES > 0) ? FILL_CYCLES - 1 : 0);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    // With no fill window the controller starts hazard checking immediately.
    localparam state_t RESET_STATE = (FILL_CYCLES == 0) ? ST_RUN : ST_FILL;

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_q,  fill_d;
    logic [WAIT_W-1:0]   wait_q,  wait_d;
    logic                mem_err_q, mem_err_d;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic                load_use;
    logic [WAIT_W-1:0]   wait_inc;
    logic                pcen_w;
    logic                ifiden_w;
    logic                flush_w;
    logic                mstall_w;

    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign wait_inc = wait_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        pcen_w    = 1'b1;
        ifiden_w  = 1'b1;
        flush_w   = 1'b0;
        mstall_w  = 1'b0;

        case (state_q)
            ST_FILL: begin
                // Pipeline registers hold no valid instructions yet: ignore inputs.
                if (fill_q == FILL_LAST) begin
                    state_d = ST_RUN;
                    fill_d  = '0;
                end else begin
                    fill_d  = fill_q + 1'b1;
                end
            end

            ST_RUN: begin
                // Memory stall outranks load-use; the hazard is re-checked once
                // the access completes because ID/EX contents are frozen meanwhile.
                if (mem_req && !mem_ready) begin
                    pcen_w   = 1'b0;
                    ifiden_w = 1'b0;
                    mstall_w = 1'b1;
                    state_d  = ST_MEMWAIT;
                    wait_d   = WAIT_W'(1);
                end else if (load_use) begin
                    pcen_w   = 1'b0;
                    ifiden_w = 1'b0;
                    flush_w  = 1'b1;
                end
            end

            ST_MEMWAIT: begin
                // Stay frozen through the ready cycle so the data is captured
                // on that edge.
                pcen_w   = 1'b0;
                ifiden_w = 1'b0;
                mstall_w = 1'b1;
                if (mem_ready || !mem_req) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else if (wait_inc >= WAIT_LIMIT) begin
                    // Give up on the access and flag it; the flag is sticky.
                    mem_err_d = 1'b1;
                    state_d   = ST_RUN;
                    wait_d    = '0;
                end else begin
                    wait_d  = wait_inc;
                end
            end

            default: begin
                state_d = RESET_STATE;
                fill_d  = '0;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            fill_q      <= '0;
            wait_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            if (!pcen_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    // Reset forces the run-free output pattern even when the reset state is RUN.
    assign PCEn      = rst | pcen_w;
    assign IFIDEn    = rst | ifiden_w;
    assign IDEXFlush = ~rst & flush_w;
    assign mem_stall = ~rst & mstall_w;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire
